carryskip_add_sched: RTL
========================

CARRYSKIP_ADD_SCHED -- requirements
Module: carryskip_add_sched

Interface
REQ-001 The block SHALL have parameter NBYTES, default 4, giving the operand width in bytes; W = 8*NBYTES.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, reset; asynchronous, active-high.
REQ-004 The block SHALL have port req_valid, input, 2 bits, per-requester request valid (bit i = requester i).
REQ-005 The block SHALL have port req_ready, output, 2 bits, per-requester accept; at most one bit high.
REQ-006 The block SHALL have port req_a, input, 2*W bits, operand A; requester i at bits [i*W +: W].
REQ-007 The block SHALL have port req_b, input, 2*W bits, operand B, packed as req_a.
REQ-008 The block SHALL have port req_cin, input, 2 bits, per-requester carry-in.
REQ-009 The block SHALL have port add_a, output, 8 bits, A slice driven to the shared 8-bit carry-skip adder.
REQ-010 The block SHALL have port add_b, output, 8 bits, B slice driven to the shared adder.
REQ-011 The block SHALL have port add_cin, output, 1 bit, carry-in driven to the shared adder.
REQ-012 The block SHALL have port add_sum, input, 8 bits, combinational sum returned by the shared adder.
REQ-013 The block SHALL have port add_cout, input, 1 bit, combinational carry-out returned by the shared adder.
REQ-014 The block SHALL have port rsp_valid, output, 1 bit, result valid.
REQ-015 The block SHALL have port rsp_ready, input, 1 bit, consumer accepts result.
REQ-016 The block SHALL have port rsp_sum, output, W bits, (A + B + cin) mod 2^W.
REQ-017 The block SHALL have port rsp_cout, output, 1 bit, carry out of bit W-1.
REQ-018 The block SHALL have port rsp_id, output, 1 bit, index of the requester that owns the result.

Function
REQ-019 The block SHALL implement FSM states IDLE, RUN, RESP.
REQ-020 In IDLE, with one req_valid bit high, the block SHALL grant that requester; with both high, it SHALL grant the one not served last (round-robin).
REQ-021 req_ready SHALL be high only in IDLE, only for the granted bit, combinationally from req_valid and the last-served pointer.
REQ-022 On an edge with req_valid[g] & req_ready[g], the block SHALL capture A, B, cin and g, clear the byte index, set carry = cin and enter RUN.
REQ-023 A requester dropping req_valid before handshake SHALL cause no capture and no state change.
REQ-024 In RUN, add_a/add_b SHALL carry byte [idx] of captured A/B and add_cin SHALL carry the carry register; all three SHALL be 0 outside RUN.
REQ-025 Each RUN edge SHALL store add_sum into rsp_sum byte [idx], load add_cout into the carry register and increment idx.
REQ-026 On the RUN edge with idx = NBYTES-1, the block SHALL enter RESP with rsp_cout = add_cout; rsp_valid SHALL go high exactly NBYTES cycles after the accept edge.
REQ-027 In RESP, rsp_valid SHALL stay high and rsp_sum/rsp_cout/rsp_id SHALL stay stable until rsp_ready is high on an edge.
REQ-028 On the RESP handshake edge, the block SHALL update the last-served pointer to rsp_id and return to IDLE; no new request is accepted in that same cycle.
REQ-029 Arithmetic SHALL wrap modulo 2^W; overflow is reported only through rsp_cout.

Reset
REQ-030 While rst is high, all outputs SHALL be 0 immediately, state SHALL be IDLE, and the last-served pointer SHALL be 1 so requester 0 wins the first tie.
REQ-031 rst asserted mid-RUN or in RESP SHALL discard the operation with no response.

Verification
REQ-032 Bench SHALL cover: req0 A=0x12345678, B=0x11111111, cin=0 -> add_a sequence 0x78,0x56,0x34,0x12; rsp_sum=0x23456789, rsp_cout=0, rsp_id=0, rsp_valid 4 cycles after accept.
REQ-033 Bench SHALL cover: req1 A=0xFFFFFFFF, B=0x00000000, cin=1 -> rsp_sum=0x00000000, rsp_cout=1, rsp_id=1.
REQ-034 Bench SHALL cover: both req_valid held high for 4 transactions -> rsp_id sequence 0,1,0,1.
REQ-035 Bench SHALL cover: rsp_ready low for 5 cycles in RESP -> rsp outputs stable, req_ready=0, add_* = 0.
REQ-036 Bench SHALL cover: rst pulsed during RUN byte 2 -> outputs 0 at once; the next request after release returns a correct sum.
REQ-037 Bench SHALL cover: A=0x000000FF, B=0x00000001 -> add_cin sequence 0,1,0,0; rsp_sum=0x00000100.

Source files
------------

// File: rtl/carryskip_add_sched.sv
// Two-requester scheduler that time-shares one external 8-bit adder to add
// W-bit operands a byte per cycle, least-significant byte first.
module carryskip_add_sched #(
   parameter  int NBYTES = 4,
   localparam int W      = 8 * NBYTES
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [1:0]     req_valid,
   output logic [1:0]     req_ready,
   input  logic [2*W-1:0] req_a,
   input  logic [2*W-1:0] req_b,
   input  logic [1:0]     req_cin,
   output logic [7:0]     add_a,
   output logic [7:0]     add_b,
   output logic           add_cin,
   input  logic [7:0]     add_sum,
   input  logic           add_cout,
   output logic           rsp_valid,
   input  logic           rsp_ready,
   output logic [W-1:0]   rsp_sum,
   output logic           rsp_cout,
   output logic           rsp_id
);

   localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

   state_t                 state_q, state_d;
   logic [NBYTES-1:0][7:0] a_q, a_d;
   logic [NBYTES-1:0][7:0] b_q, b_d;
   logic [NBYTES-1:0][7:0] sum_q, sum_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic                   carry_q, carry_d;
   logic                   cout_q, cout_d;
   logic                   id_q, id_d;
   logic                   last_q, last_d;
   logic [1:0]             grant;
   logic                   gsel;

   // On a tie the requester that was not served last wins.
   always_comb begin
      grant = 2'b00;
      if (state_q == IDLE && !rst) begin
         if (req_valid == 2'b11) grant = last_q ? 2'b01 : 2'b10;
         else                    grant = req_valid;
      end
   end

   assign req_ready = grant;
   assign gsel      = grant[1];

   always_comb begin
      // NOTE: every _d takes its _q first, so no path can leave one unassigned and infer a latch.
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      id_d    = id_q;
      last_d  = last_q;
      unique case (state_q)
         IDLE: begin
            if (|(req_valid & grant)) begin
               a_d     = gsel ? req_a[2*W-1:W] : req_a[W-1:0];
               b_d     = gsel ? req_b[2*W-1:W] : req_b[W-1:0];
               carry_d = req_cin[gsel];
               id_d    = gsel;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d[idx_q] = add_sum;
            carry_d      = add_cout;
            idx_d        = idx_q + 1'b1;
            if (idx_q == IW'(NBYTES - 1)) begin
               cout_d  = add_cout;
               state_d = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               last_d  = id_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Reset parks the pointer on requester 1 so requester 0 takes the first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         id_q    <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge values.
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         id_q    <= id_d;
         last_q  <= last_d;
      end
   end

   assign add_a     = (state_q == RUN) ? a_q[idx_q] : 8'h00;
   assign add_b     = (state_q == RUN) ? b_q[idx_q] : 8'h00;
   assign add_cin   = (state_q == RUN) & carry_q;
   assign rsp_valid = (state_q == RESP);
   assign rsp_sum   = (state_q == RESP) ? sum_q : '0;
   assign rsp_cout  = (state_q == RESP) & cout_q;
   assign rsp_id    = (state_q == RESP) & id_q;

endmodule
